// File: rtl/jt12_kon_pkg.sv
// Shared definitions for the key-on sequencer: CSM state encoding, the slot
// order of operator groups, and the slot count for a given channel count.
package jt12_kon_pkg;

  typedef enum logic [1:0] {
    CSM_IDLE,
    CSM_ARMED,
    CSM_ACTIVE
  } csm_state_e;

  // Operator groups are visited S1, S3, S2, S4; entries are key-register bit indices.
  localparam logic [1:0] OP_ORDER [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  // Channel 3 (zero-based index 2) is the one CSM keys on.
  localparam logic [2:0] CSM_CH = 3'd2;

  function automatic int unsigned slot_count(input int unsigned n_ch);
    return 4 * n_ch;
  endfunction

  function automatic logic [1:0] op_bit(input logic [1:0] grp);
    return OP_ORDER[grp];
  endfunction

endpackage

// File: rtl/jt12_kon_csm.sv
// CSM key-on controller: arms on timer A overflow, then forces channel 3
// key-on for one full slot round starting at slot 0.
module jt12_kon_csm
  import jt12_kon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       csm_i,
  input  logic       tmr_a_ovf_i,
  input  logic       cnt_zero_i,
  input  logic [4:0] slots_i,
  output logic       force_o
);

  csm_state_e state_q, state_d;
  logic [4:0] left_q, left_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CSM_IDLE;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    if (clk_en) begin
      if (!csm_i) begin
        state_d = CSM_IDLE;
      end else begin
        case (state_q)
          CSM_IDLE: begin
            if (tmr_a_ovf_i) state_d = CSM_ARMED;
          end
          CSM_ARMED: begin
            // Remaining count covers the slots after the entry edge.
            if (cnt_zero_i) begin
              state_d = CSM_ACTIVE;
              left_d  = slots_i - 5'd1;
            end
          end
          CSM_ACTIVE: begin
            if (left_q == '0) state_d = CSM_IDLE;
            else              left_d  = left_q - 5'd1;
          end
          default: state_d = CSM_IDLE;
        endcase
      end
    end
  end

  assign force_o = (state_q == CSM_ACTIVE);

endmodule

// File: rtl/jt12_kon_seq.sv
// Key-on register bank and slot sequencer: walks every operator slot and
// emits the serial key-on bit for the envelope generator.
module jt12_kon_seq
  import jt12_kon_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       kon_wr,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_op,
  input  logic       csm,
  input  logic       tmr_a_ovf,
  output logic       keyon_I,
  output logic [4:0] slot,
  output logic       zero
);

  localparam int unsigned NUM_CH_U  = num_ch;
  localparam int unsigned SLOTS     = slot_count(NUM_CH_U);
  localparam logic [4:0]  SLOTS_V   = 5'(SLOTS);
  localparam logic [4:0]  LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [2:0]  LAST_CH   = 3'(NUM_CH_U - 1);

  logic [4:0] cnt_q, cnt_d;
  logic [2:0] ch_q, ch_d;
  logic [1:0] grp_q, grp_d;
  logic [3:0] key_q [num_ch];
  logic       keyon_q, slot_zero_q;
  logic [4:0] slot_q;

  logic       wr_ok;
  logic [2:0] wr_idx;
  logic [3:0] key_sel;
  logic       kon_d;
  logic       force_on;

  always_comb begin
    wr_idx = kon_ch[2] ? (3'(kon_ch[1:0]) + 3'd3) : 3'(kon_ch[1:0]);
    wr_ok  = kon_wr && (kon_ch[1:0] != 2'd3) && ((NUM_CH_U == 6) || !kon_ch[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH_U; i++) key_q[i] <= '0;
    end else if (clk_en && wr_ok) begin
      for (int unsigned i = 0; i < NUM_CH_U; i++) begin
        if (wr_idx == 3'(i)) key_q[i] <= kon_op;
      end
    end
  end

  // Channel and group counters track cnt % num_ch and cnt / num_ch without dividers.
  always_comb begin
    cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + 5'd1;
    if (ch_q == LAST_CH) begin
      ch_d  = '0;
      grp_d = grp_q + 2'd1;
    end else begin
      ch_d  = ch_q + 3'd1;
      grp_d = grp_q;
    end
  end

  always_comb begin
    key_sel = '0;
    for (int unsigned i = 0; i < NUM_CH_U; i++) begin
      if (ch_q == 3'(i)) key_sel = key_q[i];
    end
    kon_d = key_sel[op_bit(grp_q)] | (force_on && (ch_q == CSM_CH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ch_q        <= '0;
      grp_q       <= '0;
      slot_q      <= '0;
      slot_zero_q <= 1'b0;
      keyon_q     <= 1'b0;
    end else if (clk_en) begin
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      grp_q       <= grp_d;
      slot_q      <= cnt_q;
      slot_zero_q <= (cnt_q == '0);
      keyon_q     <= kon_d;
    end
  end

  jt12_kon_csm u_csm (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .csm_i       (csm),
    .tmr_a_ovf_i (tmr_a_ovf),
    .cnt_zero_i  (cnt_q == '0),
    .slots_i     (SLOTS_V),
    .force_o     (force_on)
  );

  assign keyon_I = keyon_q;
  assign slot    = slot_q;
  assign zero    = slot_zero_q;

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Directed bench for the key-on sequencer: a 6-channel and a 3-channel
// instance share stimulus; expected key-on slots are worked out by hand.
module tb_jt12_kon_seq;

  logic       clk = 1'b0;
  logic       rst, clk_en, kon_wr, csm, tmr_a_ovf;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;
  logic       keyon6, zero6, keyon3, zero3;
  logic [4:0] slot6, slot3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jt12_kon_seq #(.num_ch(6)) u_dut6 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .kon_wr(kon_wr), .kon_ch(kon_ch),
    .kon_op(kon_op), .csm(csm), .tmr_a_ovf(tmr_a_ovf),
    .keyon_I(keyon6), .slot(slot6), .zero(zero6)
  );

  jt12_kon_seq #(.num_ch(3)) u_dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .kon_wr(kon_wr), .kon_ch(kon_ch),
    .kon_op(kon_op), .csm(csm), .tmr_a_ovf(tmr_a_ovf),
    .keyon_I(keyon3), .slot(slot3), .zero(zero3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clk_en edge reading out slot s; optionally also checks the 3-channel instance.
  task automatic do_slot(input string tag, input int s, input bit exp6, input bit exp3, input bit chk3);
    step();
    chk($sformatf("%s s%0d slot6", tag, s), 32'(slot6), 32'(s));
    chk($sformatf("%s s%0d zero6", tag, s), 32'(zero6), 32'(s == 0));
    chk($sformatf("%s s%0d keyon6", tag, s), 32'(keyon6), 32'(exp6));
    if (chk3) begin
      chk($sformatf("%s s%0d slot3", tag, s), 32'(slot3), 32'(s % 12));
      chk($sformatf("%s s%0d zero3", tag, s), 32'(zero3), 32'((s % 12) == 0));
      chk($sformatf("%s s%0d keyon3", tag, s), 32'(keyon3), 32'(exp3));
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; kon_wr = 1'b0; csm = 1'b0; tmr_a_ovf = 1'b0;
    kon_ch = '0; kon_op = '0;
    repeat (3) step();
    chk("rst slot6", 32'(slot6), 0);
    chk("rst zero6", 32'(zero6), 0);
    chk("rst keyon6", 32'(keyon6), 0);
    chk("rst slot3", 32'(slot3), 0);
    chk("rst zero3", 32'(zero3), 0);
    rst = 1'b0;

    // Idle round: counter walk, zero flag, no key-on.
    for (int s = 0; s < 24; s++) do_slot("idle", s, 1'b0, 1'b0, 1'b1);

    // ch4 with S1+S4 keyed: slots 3 and 21; invalid on the 3-channel part.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 24; s++) begin
        if (r == 0 && s == 0) begin kon_wr = 1'b1; kon_ch = 3'd4; kon_op = 4'b1001; end
        do_slot($sformatf("ch4 r%0d", r), s, (s == 3 || s == 21), 1'b0, 1'b1);
        kon_wr = 1'b0;
      end
    end

    // Writes to channel codes 3 and 7 are dropped.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 24; s++) begin
        if (r == 0 && s == 0) begin kon_wr = 1'b1; kon_ch = 3'd3; kon_op = 4'hF; end
        if (r == 0 && s == 1) begin kon_wr = 1'b1; kon_ch = 3'd7; kon_op = 4'hF; end
        do_slot($sformatf("inv r%0d", r), s, (s == 3 || s == 21), 1'b0, 1'b1);
        kon_wr = 1'b0;
      end
    end

    // CSM: arm at slot 10, one forced round for channel 3, re-trigger while active ignored.
    csm = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 24; s++) begin
        if ((r == 0 && s == 10) || (r == 1 && s == 12)) tmr_a_ovf = 1'b1;
        do_slot($sformatf("csm r%0d", r), s,
                (s == 3 || s == 21 || (r == 1 && (s % 6) == 2)), 1'b0, 1'b0);
        tmr_a_ovf = 1'b0;
      end
    end

    // Dropping csm mid-active returns to idle immediately.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 24; s++) begin
        if (r == 0 && s == 10) tmr_a_ovf = 1'b1;
        if (r == 1 && s == 5) csm = 1'b0;
        do_slot($sformatf("csmoff r%0d", r), s,
                (s == 3 || s == 21 || (r == 1 && s == 2)), 1'b0, 1'b0);
        tmr_a_ovf = 1'b0;
      end
    end

    // Reset mid-active with competing write and timer pulse.
    csm = 1'b1;
    for (int s = 0; s < 24; s++) begin
      if (s == 10) tmr_a_ovf = 1'b1;
      do_slot("arm", s, (s == 3 || s == 21), 1'b0, 1'b0);
      tmr_a_ovf = 1'b0;
    end
    for (int s = 0; s < 5; s++) do_slot("act", s, (s == 2 || s == 3), 1'b0, 1'b0);
    rst = 1'b1; kon_wr = 1'b1; kon_ch = 3'd0; kon_op = 4'hF; tmr_a_ovf = 1'b1;
    step();
    step();
    chk("midrst slot6", 32'(slot6), 0);
    chk("midrst zero6", 32'(zero6), 0);
    chk("midrst keyon6", 32'(keyon6), 0);
    chk("midrst keyon3", 32'(keyon3), 0);
    rst = 1'b0; kon_wr = 1'b0; tmr_a_ovf = 1'b0;
    for (int s = 0; s < 24; s++) do_slot("postrst", s, 1'b0, 1'b0, 1'b1);
    csm = 1'b0;

    // Write ch1 at cnt 0: old value read that slot; plus a clk_en=0 hold with an ignored write.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 24; s++) begin
        if (r == 0 && s == 0) begin kon_wr = 1'b1; kon_ch = 3'd0; kon_op = 4'hF; end
        if (r == 1 && s == 7) begin
          clk_en = 1'b0; kon_wr = 1'b1; kon_ch = 3'd0; kon_op = 4'h0;
          for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d slot6", k), 32'(slot6), 6);
            chk($sformatf("hold%0d keyon6", k), 32'(keyon6), 1);
            chk($sformatf("hold%0d zero6", k), 32'(zero6), 0);
          end
          kon_wr = 1'b0; clk_en = 1'b1;
        end
        do_slot($sformatf("ch1 r%0d", r), s,
                ((s % 6) == 0) && !(r == 0 && s == 0),
                (((s % 12) % 3) == 0) && !(r == 0 && s == 0), 1'b1);
        kon_wr = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
